// File: rtl/counter_address_seq.sv
// counter_address_seq: programmable start/stop/stride address sweep with saturate or wrap termination.
module counter_address_seq #(
  parameter int Width   = 8,
  parameter int DefStop = 92,
  parameter int DefStep = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       opc_i,
  input  logic             cfg_we_i,
  input  logic [Width-1:0] start_i,
  input  logic [Width-1:0] stop_i,
  input  logic [Width-1:0] step_i,
  input  logic             dir_i,
  input  logic             wrap_en_i,
  output logic [Width-1:0] count_o,
  output logic             flag_o,
  output logic             done_o,
  output logic             wrap_o,
  output logic             busy_o,
  output logic             cfg_err_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [Width-1:0] count_q, count_d, start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic dir_q, dir_d, wrap_en_q, wrap_en_d, done_q, done_d, wrap_q, wrap_d, err_q, err_d;
  logic cfg_ok, reach;
  logic [Width:0] nxt;
  assign cfg_ok = cfg_we_i && state_q == IDLE;
  // One extra bit catches both carry-out (up) and borrow (down) as crossing.
  assign nxt = dir_q ? {1'b0, count_q} - {1'b0, step_q} : {1'b0, count_q} + {1'b0, step_q};
  assign reach = dir_q ? (nxt[Width] || nxt[Width-1:0] <= stop_q) : (nxt >= {1'b0, stop_q});
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      start_q   <= '0;
      stop_q    <= Width'(DefStop);
      step_q    <= Width'(DefStep);
      dir_q     <= 1'b0;
      wrap_en_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      wrap_en_q <= wrap_en_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    start_d   = start_q;
    stop_d    = stop_q;
    step_d    = step_q;
    dir_d     = dir_q;
    wrap_en_d = wrap_en_q;
    err_d     = err_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    if (cfg_ok) begin
      start_d   = start_i;
      stop_d    = stop_i;
      step_d    = step_i;
      dir_d     = dir_i;
      wrap_en_d = wrap_en_i;
      count_d   = start_i;
      err_d     = step_i == '0 || (dir_i ? stop_i > start_i : stop_i < start_i);
    end else if (opc_i[1] == opc_i[0]) begin
      count_d = start_q;
      state_d = IDLE;
    end else if (opc_i == 2'b10 && (state_q == RUN || (state_q == IDLE && !err_q))) begin
      state_d = RUN;
      if (!reach) count_d = nxt[Width-1:0];
      else if (wrap_en_q) begin
        count_d = start_q;
        wrap_d  = 1'b1;
      end else begin
        count_d = stop_q;
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end
  always_comb begin
    count_o   = count_q;
    flag_o    = count_q == stop_q;
    done_o    = done_q;
    wrap_o    = wrap_q;
    busy_o    = state_q == RUN;
    cfg_err_o = err_q;
  end
endmodule

// File: tb/tb_counter_address_seq.sv
// tb_counter_address_seq: directed test-plan steps plus random traffic against an integer reference model.
module tb_counter_address_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] opc = 2'b01;
  logic       we = 1'b0;
  logic [7:0] start_v = '0, stop_v = '0, step_v = '0;
  logic       dir_v = 1'b0, wrap_v = 1'b0;
  logic [7:0] count;
  logic       flag, done, wrap, busy, err;
  int n_pass = 0, n_total = 0;
  int m_cnt, m_start, m_stop, m_step, m_dir, m_wrap, m_st, m_err, m_done, m_wp;

  counter_address_seq dut (
    .clk_i(clk), .rst_i(rst_n), .opc_i(opc), .cfg_we_i(we),
    .start_i(start_v), .stop_i(stop_v), .step_i(step_v), .dir_i(dir_v), .wrap_en_i(wrap_v),
    .count_o(count), .flag_o(flag), .done_o(done), .wrap_o(wrap), .busy_o(busy), .cfg_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
  endtask

  // Model state: m_st 0 idle, 1 sweeping, 2 finished; arithmetic in plain ints so nothing wraps.
  task automatic tick(input logic rn, input logic [1:0] op, input logic w_en,
                      input int s, input int p, input int t, input int d, input int w);
    int n;
    @(negedge clk);
    rst_n = rn; opc = op; we = w_en;
    start_v = 8'(s); stop_v = 8'(p); step_v = 8'(t); dir_v = d[0]; wrap_v = w[0];
    if (!rn) begin
      m_cnt = 0; m_start = 0; m_stop = 92; m_step = 1; m_dir = 0; m_wrap = 0;
      m_st = 0; m_err = 0; m_done = 0; m_wp = 0;
    end else begin
      m_done = 0; m_wp = 0;
      if (w_en && m_st == 0) begin
        m_start = s; m_stop = p; m_step = t; m_dir = d; m_wrap = w; m_cnt = s;
        m_err = (t == 0 || (d != 0 ? p > s : p < s)) ? 1 : 0;
      end else if (op == 2'b00 || op == 2'b11) begin
        m_cnt = m_start; m_st = 0;
      end else if (op == 2'b10 && (m_st == 1 || (m_st == 0 && m_err == 0))) begin
        n = m_dir != 0 ? m_cnt - m_step : m_cnt + m_step;
        m_st = 1;
        if (m_dir != 0 ? n > m_stop : n < m_stop) m_cnt = n;
        else if (m_wrap != 0) begin m_cnt = m_start; m_wp = 1; end
        else begin m_cnt = m_stop; m_st = 2; m_done = 1; end
      end
    end
    @(posedge clk);
    #1;
    chk("count", 32'(count), m_cnt);
    chk("flag", 32'(flag), (m_cnt == m_stop) ? 1 : 0);
    chk("done", 32'(done), m_done);
    chk("wrap", 32'(wrap), m_wp);
    chk("busy", 32'(busy), (m_st == 1) ? 1 : 0);
    chk("cfg_err", 32'(err), m_err);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) tick(1'b1, 2'b10, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int s, input int p, input int t, input int d, input int w);
    tick(1'b1, 2'b01, 1'b1, s, p, t, d, w);
  endtask

  initial begin
    int r, s, p;
    tick(1'b0, 2'b01, 1'b0, 0, 0, 0, 0, 0);
    steps(95);
    tick(1'b1, 2'b00, 1'b0, 0, 0, 0, 0, 0);
    cfg(10, 50, 7, 0, 0);
    steps(8);
    tick(1'b1, 2'b11, 1'b0, 0, 0, 0, 0, 0);
    cfg(40, 4, 12, 1, 1);
    steps(10);
    tick(1'b1, 2'b00, 1'b0, 0, 0, 0, 0, 0);
    cfg(5, 9, 0, 0, 0);
    steps(2);
    cfg(30, 20, 3, 0, 0);
    steps(2);
    cfg(240, 255, 10, 0, 0);
    steps(1);
    tick(1'b1, 2'b10, 1'b1, 0, 100, 1, 0, 1);
    steps(2);
    tick(1'b1, 2'b00, 1'b0, 0, 0, 0, 0, 0);
    cfg(7, 7, 3, 0, 0);
    steps(2);
    cfg(7, 7, 3, 1, 1);
    steps(3);
    tick(1'b0, 2'b01, 1'b0, 0, 0, 0, 0, 0);
    steps(30);
    tick(1'b0, 2'b10, 1'b1, 1, 2, 3, 0, 0);
    steps(3);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      s = $urandom_range(0, 255);
      p = $urandom_range(0, 255);
      if (r < 3) tick(1'b0, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, s, p, 1, 0, 0);
      else if (r < 10)
        tick(1'b1, 2'($urandom_range(0, 3)), 1'b1, s, p, $urandom_range(0, 40),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : ((p < s) ? 1 : 0),
             $urandom_range(0, 1));
      else if (r < 88) steps(1);
      else tick(1'b1, 2'($urandom_range(0, 3)), 1'b0, 0, 0, 0, 0, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
